// File: rtl/ddr_port_arbiter.sv
// Shared DDR port arbiter: locks a grant until burst done, enforces a one-cycle gap
// between grants, fixed-priority or round-robin selection, and a hold-timeout watchdog.
module ddr_port_arbiter #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned MODE     = 0,
  parameter int unsigned HOLD_MAX = 256,
  localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic [NUM_CH-1:0] done,
  output logic [NUM_CH-1:0] grant,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              timeout
);

  localparam int unsigned CNT_W    = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam int unsigned CNT_LAST = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [IDX_W-1:0]  rr_last, rr_d;
  logic [NUM_CH-1:0] grant_d;
  logic [IDX_W-1:0]  idx_d;
  logic              timeout_d;
  logic [IDX_W-1:0]  win;
  logic [NUM_CH-1:0] req_sh;
  int unsigned       pos;
  logic              done_hit;

  // Winner selection; later loop iterations override earlier ones
  always_comb begin
    win    = '0;
    req_sh = '0;
    pos    = 0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        req_sh = req >> i;
        if (req_sh[0]) win = IDX_W'(i);
      end
    end else begin
      for (int unsigned off = NUM_CH; off >= 1; off--) begin
        pos = 32'(rr_last) + off;
        if (pos >= NUM_CH) pos = pos - NUM_CH;
        req_sh = req >> pos;
        if (req_sh[0]) win = IDX_W'(pos);
      end
    end
  end

  assign done_hit = |(done & grant);

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    grant_d   = grant;
    idx_d     = grant_idx;
    cnt_d     = cnt;
    rr_d      = rr_last;
    timeout_d = 1'b0;
    case (state)
      ST_IDLE, ST_GAP: begin
        if (|req) begin
          state_d = ST_GRANT;
          grant_d = NUM_CH'(1) << win;
          idx_d   = win;
          cnt_d   = '0;
          rr_d    = win;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          idx_d   = '0;
        end
      end
      ST_GRANT: begin
        if (done_hit) begin
          state_d = ST_GAP;
          grant_d = '0;
          idx_d   = '0;
        end else if ((HOLD_MAX > 0) && (cnt == CNT_W'(CNT_LAST))) begin
          state_d   = ST_GAP;
          grant_d   = '0;
          idx_d     = '0;
          timeout_d = 1'b1;
        end else if (cnt != '1) begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rr_last     <= IDX_W'(NUM_CH - 1);
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      rr_last     <= rr_d;
      grant       <= grant_d;
      grant_valid <= |grant_d;
      grant_idx   <= idx_d;
      timeout     <= timeout_d;
    end
  end

endmodule
